// File: rtl/pulse_train_pkg.sv
// Shared types and helpers for the pulse train generator.
package pulse_train_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int WIDTH_W_DEF = 8;
   localparam int CNT_W_DEF   = 8;

   // A phase length of zero still occupies one clock.
   function automatic logic [31:0] clamp_min1(input logic [31:0] len);
      return (len == 32'd0) ? 32'd1 : len;
   endfunction

endpackage

// File: rtl/pulse_train_gen_phase_down_counter.sv
// Per-phase countdown: loaded with (length-1), zero_o marks the last cycle of the phase.
module phase_down_counter #(
   parameter int WIDTH_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic [WIDTH_W-1:0] load_val_i,
   input  logic               en_i,
   output logic               zero_o
);

   logic [WIDTH_W-1:0] count_q;
   logic [WIDTH_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - WIDTH_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable rectangular pulse train with start/busy/done handshake and abort.
// Optional edge reference outputs are enabled by defining PULSE_TRAIN_EDGE_FLAGS_EN.
module pulse_train_gen
   import pulse_train_pkg::*;
#(
   parameter int WIDTH_W = WIDTH_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [WIDTH_W-1:0] high_cycles_i,
   input  logic [WIDTH_W-1:0] low_cycles_i,
   input  logic [CNT_W-1:0]   num_pulses_i,
   output logic               a_o,
   output logic               busy_o,
   output logic               done_o
`ifdef PULSE_TRAIN_EDGE_FLAGS_EN
   ,
   output logic               rising_edge_o,
   output logic               falling_edge_o
`endif
);

   state_t             state_q, state_d;
   logic               a_q, a_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH_W-1:0] high_q, high_d;
   logic [WIDTH_W-1:0] low_q, low_d;
   logic [CNT_W-1:0]   num_q, num_d;
   logic [CNT_W-1:0]   pulse_q, pulse_d;
   logic [CNT_W-1:0]   pulse_inc;
   logic               load;
   logic [WIDTH_W-1:0] load_val;
   logic               phase_en;
   logic               phase_zero;

   function automatic logic [WIDTH_W-1:0] phase_load(input logic [WIDTH_W-1:0] len);
      return WIDTH_W'(clamp_min1(32'(len)) - 32'd1);
   endfunction

   // pulse_q < num_q whenever this is used, so the increment never wraps.
   assign pulse_inc = pulse_q + CNT_W'(1);
   assign phase_en  = (state_q == HIGH) || (state_q == LOW);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      high_d   = high_q;
      low_d    = low_q;
      num_d    = num_q;
      pulse_d  = pulse_q;
      load     = 1'b0;
      load_val = phase_load(high_q);
      if (abort_i && (state_q != IDLE)) begin
         state_d = IDLE;
         a_d     = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  high_d  = high_cycles_i;
                  low_d   = low_cycles_i;
                  num_d   = num_pulses_i;
                  pulse_d = '0;
                  busy_d  = 1'b1;
                  if (num_pulses_i != '0) begin
                     state_d  = HIGH;
                     a_d      = 1'b1;
                     load     = 1'b1;
                     load_val = phase_load(high_cycles_i);
                  end else begin
                     state_d = DONE;
                     a_d     = 1'b0;
                     done_d  = 1'b1;
                  end
               end
            end
            HIGH: begin
               if (phase_zero) begin
                  state_d  = LOW;
                  a_d      = 1'b0;
                  load     = 1'b1;
                  load_val = phase_load(low_q);
               end
            end
            LOW: begin
               if (phase_zero) begin
                  pulse_d = pulse_inc;
                  if (pulse_inc < num_q) begin
                     state_d  = HIGH;
                     a_d      = 1'b1;
                     load     = 1'b1;
                     load_val = phase_load(high_q);
                  end else begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
               a_d     = 1'b0;
               busy_d  = 1'b0;
            end
            default: begin
               state_d = IDLE;
               a_d     = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         high_q  <= '0;
         low_q   <= '0;
         num_q   <= '0;
         pulse_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         high_q  <= high_d;
         low_q   <= low_d;
         num_q   <= num_d;
         pulse_q <= pulse_d;
      end
   end

   phase_down_counter #(
      .WIDTH_W (WIDTH_W)
   ) u_phase_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load),
      .load_val_i (load_val),
      .en_i       (phase_en),
      .zero_o     (phase_zero)
   );

   assign a_o    = a_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

`ifdef PULSE_TRAIN_EDGE_FLAGS_EN
   // Flags are registered alongside a_q so they coincide with the a_o transition.
   logic rise_q, fall_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= a_d & ~a_q;
         fall_q <= ~a_d & a_q;
      end
   end

   assign rising_edge_o  = rise_q;
   assign falling_edge_o = fall_q;
`endif

endmodule
